instruction_fetch: RTL and testbench

Control-side reader for the instruction cache. After a start pulse it walks a 10-bit program counter through the 1024-entry instruction memory and reads one instruction per cycle over the cache's combinational ctrl read port. Fetched instructions are buffered in a small prefetch FIFO and handed to the decoder over a valid/ready handshake. Fetching stops when a HALT instruction is fetched; a redirect input supports jumps.

---
 rtl/tpu_isa_pkg.sv | 9 +
 rtl/ifetch_fifo.sv | 42 ++++
 rtl/instruction_fetch.sv | 93 +++++++++
 tb/tb_instruction_fetch.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/tpu_isa_pkg.sv
// tpu_isa_pkg: shared ISA constants and the instruction-fetch state type
package tpu_isa_pkg;
  localparam int INS_LEN = 54;
  localparam int ICACHE_AW = 10;
  localparam int OPCODE_MSB = INS_LEN - 1;
  localparam int OPCODE_LSB = INS_LEN - 4;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} ifetch_state_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: shift-register prefetch FIFO whose head entry 0 is a plain register
module ifetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [CW-1:0] count_q, count_d, wr_idx;
  assign wr_idx = count_q - CW'(pop);
  assign count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  // entries shift toward the head on pop; a push lands just behind the last survivor
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = pop ? mem_q[(i < DEPTH - 1) ? i + 1 : i] : mem_q[i];
      if (push && CW'(i) == wr_idx) mem_d[i] = din;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      count_q <= count_d;
    end
  assign dout = mem_q[0];
  assign count = count_q;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: walks the PC through the icache into a prefetch FIFO until HALT.
// Optional IFETCH_PERF_CNT_EN adds saturating fetch/stall performance counters.
module instruction_fetch import tpu_isa_pkg::*; #(
  parameter int INS_LEN = tpu_isa_pkg::INS_LEN,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ICACHE_AW-1:0] start_pc,
  input  logic                 redirect_valid,
  input  logic [ICACHE_AW-1:0] redirect_pc,
  output logic                 icache_rd_ctrl_en,
  output logic [ICACHE_AW-1:0] icache_rd_ctrl_addr,
  input  logic [INS_LEN-1:0]   icache_rd_ctrl_data,
  output logic                 ins_valid,
  input  logic                 ins_ready,
  output logic [INS_LEN-1:0]   ins_data,
  output logic [ICACHE_AW-1:0] ins_pc,
  output logic                 busy,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_stall_cnt,
`endif
  output logic                 done
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  ifetch_state_t state_q, state_d;
  logic [ICACHE_AW-1:0] pc_q, pc_d;
  logic fetch, pop, redir, full, empty, halt;
  logic [CW-1:0] count;
  assign pop = !empty && ins_ready;
  assign redir = redirect_valid && state_q != IDLE;
  assign fetch = state_q == FETCH && !redirect_valid && (!full || pop);
  assign halt = icache_rd_ctrl_data[INS_LEN-1 -: 4] == OP_HALT;
  assign done = state_q == DRAIN && count == '0 && !redirect_valid;
  assign busy = state_q != IDLE;
  assign ins_valid = !empty;
  assign icache_rd_ctrl_en = fetch;
  assign icache_rd_ctrl_addr = pc_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    if (state_q == IDLE && start) begin
      state_d = FETCH;
      pc_d = start_pc;
    end else if (redir) begin
      state_d = FETCH;
      pc_d = redirect_pc;
    end else begin
      pc_d = fetch ? pc_q + ICACHE_AW'(1) : pc_q;
      state_d = (fetch && halt) ? DRAIN : done ? IDLE : state_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  ifetch_fifo #(.W(ICACHE_AW + INS_LEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch),
    .pop   (pop),
    .flush (redir),
    .din   ({pc_q, icache_rd_ctrl_data}),
    .dout  ({ins_pc, ins_data}),
    .full  (full),
    .empty (empty),
    .count (count)
  );
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_stall_q;
  logic stall;
  assign stall = state_q == FETCH && !redirect_valid && full && !pop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else if (state_q == IDLE && start) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (fetch && !(&perf_fetch_q)) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (stall && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven cycle vectors plus wrap and reset sequences
module tb_instruction_fetch;
  logic clk = 0, rst_n = 0, start = 0, redirect_valid = 0, ins_ready = 0;
  logic [9:0] start_pc = 0, redirect_pc = 0;
  logic icache_rd_ctrl_en, ins_valid, busy, done;
  logic [9:0] icache_rd_ctrl_addr, ins_pc;
  logic [53:0] icache_rd_ctrl_data, ins_data;
  logic [53:0] imem [1024];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;
  assign icache_rd_ctrl_data = imem[icache_rd_ctrl_addr];

  instruction_fetch #(.INS_LEN(54), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .icache_rd_ctrl_en(icache_rd_ctrl_en), .icache_rd_ctrl_addr(icache_rd_ctrl_addr),
    .icache_rd_ctrl_data(icache_rd_ctrl_data), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_data(ins_data), .ins_pc(ins_pc), .busy(busy), .done(done)
  );

  typedef struct {
    logic s; logic [9:0] spc; logic rv; logic [9:0] rpc; logic rdy;
    logic en; logic [9:0] addr; logic vld; logic [9:0] pc; logic bsy; logic dn;
  } vec_t;
  vec_t vq[$];

  function automatic logic [53:0] mk(input logic [3:0] op, input int a);
    return {op, 40'(a * 12345), 10'(a)};
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic v(input logic s, input logic [9:0] spc, input logic rv, input logic [9:0] rpc,
                   input logic rdy, input logic en, input logic [9:0] addr, input logic vld,
                   input logic [9:0] pc, input logic bsy, input logic dn);
    vq.push_back('{s, spc, rv, rpc, rdy, en, addr, vld, pc, bsy, dn});
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_en"}, icache_rd_ctrl_en, 0);
    check({nm, "_addr"}, icache_rd_ctrl_addr, 0);
    check({nm, "_valid"}, ins_valid, 0);
    check({nm, "_data"}, ins_data, 0);
    check({nm, "_pc"}, ins_pc, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_done"}, done, 0);
  endtask

  // Runs a program with ready held high; expects n pcs starting at first, then one done.
  task automatic run_prog(input logic [9:0] spc, input int n, input logic [9:0] first, input string nm);
    int got = 0, dones = 0, c = 0;
    @(posedge clk); #1 start = 1; start_pc = spc; ins_ready = 1;
    @(posedge clk); #1 start = 0;
    for (c = 0; c < 40 && !(dones > 0 && !busy); c++) begin
      @(negedge clk);
      if (ins_valid) begin
        check({nm, "_pc"}, ins_pc, 10'(first + 10'(got)));
        check({nm, "_data"}, ins_data, mk(imem[ins_pc][53:50], int'(10'(first + 10'(got)))));
        got++;
      end
      if (done) dones++;
    end
    check({nm, "_count"}, got, n);
    check({nm, "_dones"}, dones, 1);
    check({nm, "_idle"}, busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = mk(4'h0, i);
    imem[5] = mk(4'hF, 5);
    imem['h202] = mk(4'hF, 'h202);
    imem['h18] = mk(4'hF, 'h18);

    // straight-line program 0..5, HALT at 5
    v(1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 1,   1, 0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 1,   1, 1, 1, 0, 1, 0);
    v(0, 0, 0, 0, 1,   1, 2, 1, 1, 1, 0);
    v(0, 0, 0, 0, 1,   1, 3, 1, 2, 1, 0);
    v(0, 0, 0, 0, 1,   1, 4, 1, 3, 1, 0);
    v(0, 0, 0, 0, 1,   1, 5, 1, 4, 1, 0);
    v(0, 0, 0, 0, 1,   0, 6, 1, 5, 1, 0);
    v(0, 0, 0, 0, 1,   0, 6, 0, 0, 1, 1);
    v(0, 0, 0, 0, 1,   0, 6, 0, 0, 0, 0);
    // backpressure from 0x10 with ready low for 10 cycles; start while busy is ignored
    v(1, 'h10, 0, 0, 0, 0, 6, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0,   1, 'h10, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0,   1, 'h11, 1, 'h10, 1, 0);
    v(0, 0, 0, 0, 0,   0, 'h12, 1, 'h10, 1, 0);
    v(0, 0, 0, 0, 0,   0, 'h12, 1, 'h10, 1, 0);
    v(1, 'h300, 0, 0, 0, 0, 'h12, 1, 'h10, 1, 0);
    for (int i = 0; i < 4; i++) v(0, 0, 0, 0, 0, 0, 'h12, 1, 'h10, 1, 0);
    v(0, 0, 0, 0, 1,   1, 'h12, 1, 'h10, 1, 0);
    v(0, 0, 0, 0, 1,   1, 'h13, 1, 'h11, 1, 0);
    v(0, 0, 0, 0, 1,   1, 'h14, 1, 'h12, 1, 0);
    // redirect to 0x200 with two entries buffered
    v(0, 0, 1, 'h200, 0, 0, 'h15, 1, 'h13, 1, 0);
    v(0, 0, 0, 0, 1,   1, 'h200, 0, 0, 1, 0);
    v(0, 0, 0, 0, 1,   1, 'h201, 1, 'h200, 1, 0);
    v(0, 0, 0, 0, 1,   1, 'h202, 1, 'h201, 1, 0);
    v(0, 0, 0, 0, 1,   0, 'h203, 1, 'h202, 1, 0);
    v(0, 0, 0, 0, 1,   0, 'h203, 0, 0, 1, 1);
    // redirect in IDLE is ignored
    v(0, 0, 1, 'h3AA, 1, 0, 'h203, 0, 0, 0, 0);
    v(0, 0, 0, 0, 1,   0, 'h203, 0, 0, 0, 0);

    #2 check_reset_outputs("por");
    @(negedge clk); rst_n = 1;
    foreach (vq[k]) begin
      @(posedge clk); #1;
      start = vq[k].s; start_pc = vq[k].spc;
      redirect_valid = vq[k].rv; redirect_pc = vq[k].rpc; ins_ready = vq[k].rdy;
      @(negedge clk);
      check($sformatf("v%0d_en", k), icache_rd_ctrl_en, vq[k].en);
      check($sformatf("v%0d_addr", k), icache_rd_ctrl_addr, vq[k].addr);
      check($sformatf("v%0d_valid", k), ins_valid, vq[k].vld);
      check($sformatf("v%0d_busy", k), busy, vq[k].bsy);
      check($sformatf("v%0d_done", k), done, vq[k].dn);
      if (vq[k].vld) begin
        check($sformatf("v%0d_pc", k), ins_pc, vq[k].pc);
        check($sformatf("v%0d_data", k), ins_data, imem[vq[k].pc]);
      end
    end
    @(posedge clk); #1 start = 0; redirect_valid = 0;

    // PC wrap: 1022, 1023, 0, 1(HALT)
    imem[1] = mk(4'hF, 1);
    run_prog(10'd1022, 4, 10'd1022, "wrap");
    imem[1] = mk(4'h0, 1);

    // asynchronous reset with a full FIFO mid-fetch
    @(posedge clk); #1 start = 1; start_pc = 'h10; ins_ready = 0;
    @(posedge clk); #1 start = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("prerst_full_valid", ins_valid, 1);
    check("prerst_full_en", icache_rd_ctrl_en, 0);
    #2 rst_n = 0;
    #1 check_reset_outputs("midrst");
    repeat (3) begin
      @(negedge clk);
      check("midrst_nodone", done, 0);
    end
    @(posedge clk); #1 rst_n = 1;
    run_prog(10'd0, 6, 10'd0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
